// File: rtl/demux2_reg_pkg.sv
// demux2_reg shared definitions
// lane select codes and default sizing
package demux_pkg;
  localparam logic LANE_A = 1'b0;
  localparam logic LANE_B = 1'b1;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;
endpackage

// File: rtl/demux2_reg_if.sv
// demux2_reg bus: one input port,
// two output lanes with handshakes
interface demux2_reg_if
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sel;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CW-1:0]    a_count;
  logic [CW-1:0]    b_count;

  modport master (
    output in_data, in_valid, in_sel,
    input  in_ready,
    input  a_data, a_valid, a_count,
    output a_ready,
    input  b_data, b_valid, b_count,
    output b_ready
  );

  modport slave (
    input  in_data, in_valid, in_sel,
    output in_ready,
    output a_data, a_valid, a_count,
    input  a_ready,
    output b_data, b_valid, b_count,
    input  b_ready
  );
endinterface

// File: rtl/demux2_reg_lane_fifo.sv
// lane_fifo: per-lane word buffer
// with registered count and valid
module lane_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             valid,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd;
  logic [AW-1:0]    wr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic             valid_q;
  logic             wr_en;
  logic             rd_en;

  assign full  = (cnt == CW'(DEPTH));
  assign wr_en = push & ~full;
  assign rd_en = pop & valid_q;
  assign rdata = mem[rd];
  assign count = cnt;
  assign valid = valid_q;

  // next occupancy; push+pop cancels out
  always_comb begin
    cnt_n = cnt;
    unique case ({wr_en, rd_en})
      2'b10:   cnt_n = cnt + 1'b1;
      2'b01:   cnt_n = cnt - 1'b1;
      default: cnt_n = cnt;
    endcase
  end

  // storage, pointers, count and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      rd      <= '0;
      wr      <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr] <= wdata;
        wr      <= wr + 1'b1;
      end
      if (rd_en)
        rd <= rd + 1'b1;
      cnt     <= cnt_n;
      valid_q <= (cnt_n != '0);
    end
  end
endmodule

// File: rtl/demux2_reg.sv
// demux2_reg: steers input words into
// two independently buffered lanes
module demux2_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic         clk,
  input logic         rst_n,
  demux2_reg_if.slave bus
);
  logic push_a;
  logic push_b;
  logic full_a;
  logic full_b;

  // ready follows only the selected lane
  assign bus.in_ready =
    (bus.in_sel == LANE_B) ? ~full_b : ~full_a;

  // decode push enable from sel
  always_comb begin
    push_a = 1'b0;
    push_b = 1'b0;
    unique case (bus.in_sel)
      LANE_A: push_a = bus.in_valid;
      LANE_B: push_b = bus.in_valid;
      default: ;
    endcase
  end

  lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_a),
    .pop   (bus.a_ready),
    .wdata (bus.in_data),
    .rdata (bus.a_data),
    .count (bus.a_count),
    .valid (bus.a_valid),
    .full  (full_a)
  );

  lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_b),
    .pop   (bus.b_ready),
    .wdata (bus.in_data),
    .rdata (bus.b_data),
    .count (bus.b_count),
    .valid (bus.b_valid),
    .full  (full_b)
  );
endmodule

// File: tb/tb_demux2_reg.sv
// demux2_reg bench: directed vectors
// plus a per-lane scoreboard stream
module tb_demux2_reg;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  demux2_reg_if #(.WIDTH(4), .DEPTH(2)) bus ();

  demux2_reg #(
    .WIDTH (4),
    .DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic s,
                       logic [3:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int nsent;
  int outa;
  int outb;
  int cyc;
  logic acc;
  logic popa;
  logic popb;
  logic [3:0] w;

  initial begin
    drive(1'b0, LANE_A, 4'h0);
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_av", 32'(bus.a_valid), 0);
    chk("rst_bv", 32'(bus.b_valid), 0);
    chk("rst_ad", 32'(bus.a_data), 0);
    chk("rst_bd", 32'(bus.b_data), 0);
    chk("rst_ac", 32'(bus.a_count), 0);
    chk("rst_bc", 32'(bus.b_count), 0);
    chk("rst_rdy", 32'(bus.in_ready), 1);
    bus.in_sel = LANE_B;
    #1;
    chk("rst_rdyb", 32'(bus.in_ready), 1);

    // steering
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    drive(1'b1, LANE_A, 4'h3);
    tick();
    chk("st_av", 32'(bus.a_valid), 1);
    chk("st_ad", 32'(bus.a_data), 3);
    chk("st_bv0", 32'(bus.b_valid), 0);
    drive(1'b1, LANE_B, 4'h7);
    tick();
    chk("st_av1", 32'(bus.a_valid), 0);
    chk("st_bv", 32'(bus.b_valid), 1);
    chk("st_bd", 32'(bus.b_data), 7);
    drive(1'b0, LANE_A, 4'h0);
    tick();
    chk("st_bv1", 32'(bus.b_valid), 0);
    chk("st_bc", 32'(bus.b_count), 0);

    // fill lane A, B keeps flowing
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    drive(1'b1, LANE_A, 4'h1);
    tick();
    drive(1'b1, LANE_A, 4'h2);
    tick();
    chk("fl_ac", 32'(bus.a_count), 2);
    chk("fl_rdy", 32'(bus.in_ready), 0);
    chk("fl_ad", 32'(bus.a_data), 1);
    drive(1'b1, LANE_B, 4'hF);
    #1;
    chk("fl_rdyb", 32'(bus.in_ready), 1);
    tick();
    chk("fl_bc", 32'(bus.b_count), 1);
    chk("fl_bd", 32'(bus.b_data), 4'hF);
    chk("fl_ac2", 32'(bus.a_count), 2);

    // full lane plus pop refuses push
    drive(1'b1, LANE_A, 4'h5);
    bus.a_ready = 1'b1;
    #1;
    chk("fp_rdy", 32'(bus.in_ready), 0);
    tick();
    chk("fp_ac1", 32'(bus.a_count), 1);
    chk("fp_ad1", 32'(bus.a_data), 2);
    chk("fp_rdy1", 32'(bus.in_ready), 1);
    tick();
    drive(1'b0, LANE_A, 4'h0);
    chk("fp_ac2", 32'(bus.a_count), 1);
    chk("fp_ad2", 32'(bus.a_data), 5);
    tick();
    chk("fp_av3", 32'(bus.a_valid), 0);
    chk("fp_bc", 32'(bus.b_count), 1);
    bus.b_ready = 1'b1;
    tick();
    chk("fp_bc0", 32'(bus.b_count), 0);

    // async reset mid-run
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    drive(1'b1, LANE_A, 4'h9);
    tick();
    drive(1'b1, LANE_A, 4'hA);
    tick();
    drive(1'b0, LANE_A, 4'h0);
    chk("ar_ac", 32'(bus.a_count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ac0", 32'(bus.a_count), 0);
    chk("ar_av0", 32'(bus.a_valid), 0);
    chk("ar_ad0", 32'(bus.a_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // streamed words with random ready
    nsent = 0;
    outa = 0;
    outb = 0;
    cyc = 0;
    while ((nsent < 16 || qa.size() != 0 ||
            qb.size() != 0) && cyc < 400) begin
      cyc++;
      w = 4'(nsent);
      drive(nsent < 16, w[0], w);
      bus.a_ready = (nsent < 16) ?
        1'($urandom_range(0, 1)) : 1'b1;
      bus.b_ready = (nsent < 16) ?
        1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("wr_ac", 32'(bus.a_count), qa.size());
      chk("wr_bc", 32'(bus.b_count), qb.size());
      if (qa.size() != 0)
        chk("wr_ad", 32'(bus.a_data), qa[0]);
      if (qb.size() != 0)
        chk("wr_bd", 32'(bus.b_data), qb[0]);
      acc = bus.in_valid &&
        ((w[0] ? qb.size() : qa.size()) < 2);
      if (bus.in_valid)
        chk("wr_rdy", 32'(bus.in_ready),
            32'(acc));
      popa = bus.a_ready && qa.size() != 0;
      popb = bus.b_ready && qb.size() != 0;
      tick();
      if (popa) begin
        void'(qa.pop_front());
        outa++;
      end
      if (popb) begin
        void'(qb.pop_front());
        outb++;
      end
      if (acc) begin
        if (w[0]) qb.push_back(w);
        else qa.push_back(w);
        nsent++;
      end
    end
    drive(1'b0, LANE_A, 4'h0);
    chk("wr_done", 32'(cyc < 400), 1);
    chk("wr_outa", 32'(outa), 8);
    chk("wr_outb", 32'(outb), 8);
    chk("wr_av", 32'(bus.a_valid), 0);
    chk("wr_bv", 32'(bus.b_valid), 0);

    $display("test done: total=%0d bad=%0d",
             n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/demux2_reg.md
# demux2_reg

Registered 1-to-2 demultiplexer for WIDTH-bit words: the distribution-side counterpart of the team's registered 2:1 word mux. Each accepted input word is steered by `in_sel` into one of two independent output lanes (A for sel=0, B for sel=1). Each lane buffers up to DEPTH words in its own FIFO and presents them on a valid/ready handshake, so a stalled lane never blocks traffic to the other lane.

## Interface
- `WIDTH`, default 4: data word width in bits.
- `DEPTH`, default 2: per-lane FIFO depth; power of two, ≥ 2.
- `CW`, derived, $clog2(DEPTH+1): occupancy count width. Not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  input word.
- `in_valid`  in  1  input word present.
- `in_sel`  in  1  destination lane: 0 = A, 1 = B; sampled with `in_data`.
- `in_ready`  out  1  selected lane can accept this cycle.
- `a_data`  out  WIDTH  lane A head word.
- `a_valid`  out  1  lane A non-empty.
- `a_ready`  in  1  lane A consumer accepts head.
- `b_data`  out  WIDTH  lane B head word.
- `b_valid`  out  1  lane B non-empty.
- `b_ready`  in  1  lane B consumer accepts head.
- `a_count`  out  CW  lane A occupancy, 0..DEPTH.
- `b_count`  out  CW  lane B occupancy, 0..DEPTH.

## Operation
- Push: `in_valid && in_ready` at a posedge writes `in_data` to the tail of lane `in_sel`. The other lane is unaffected.
- `in_ready` is combinational: lane(`in_sel`) count != DEPTH. It depends only on `in_sel` and registered state, never on `a_ready`/`b_ready`.
- Pop: `x_valid && x_ready` at a posedge removes lane x's head. Lanes pop independently; both may pop in the same cycle.
- `x_valid` = (x_count != 0). `x_data` is the head storage entry, driven directly from registers. Its value is don't-care when `x_valid`=0, but it still reads the stale entry, which is 0 after reset.
- Per-lane FIFO uses read/write pointers of width $clog2(DEPTH), which wrap modulo DEPTH, plus a separate CW-bit count.
- Count update per lane: +1 on push only, −1 on pop only, unchanged on push+pop.
- Full lane plus simultaneous pop: `in_ready`=0 for that lane, so no push that cycle. This is a deliberate choice to avoid a ready-to-ready combinational path. The push is accepted next cycle.
- Empty lane plus simultaneous push: no pop (valid=0). The word becomes visible next cycle.
- `in_sel` toggling while `in_valid`=1 and `in_ready`=0 is legal. Only the sel value present at the accepting edge matters.
- Word order within each lane is preserved. There is no ordering relation between lanes.

## Timing
- Reset (`rst_n`=0, asynchronous assert, released synchronously by the system): pointers 0, counts 0, all storage 0. Therefore `a_valid`=`b_valid`=0, `a_data`=`b_data`=0, `a_count`=`b_count`=0, and `in_ready`=1.
- Reset mid-operation discards all buffered words immediately. No handshake completes on the reset edge.
- Latency: a word pushed at edge k into an empty lane has `x_valid`=1 and `x_data`=word after edge k (1 cycle).
- Throughput: 1 word/cycle total input. Each lane sustains 1 word/cycle when its consumer holds ready=1.
- All outputs except `in_ready` are register outputs.

## Structure
- Package `demux_pkg`:
  - lane select constants `LANE_A`=1'b0, `LANE_B`=1'b1;
  - default `WIDTH`/`DEPTH` localparams.
- Sub-module `lane_fifo` (WIDTH, DEPTH): push/pop, data in/out, count, empty/full. Instantiated twice.
- Top level holds only steering (push enables decoded from `in_sel`) and the `in_ready` mux.

## Test plan
- Reset then idle: all outputs 0 and `in_ready`=1. Assert `rst_n`=0 mid-run with lane A holding 2 words → `a_count`=0 and `a_valid`=0 immediately, without waiting for a clock edge.
- Steering: push 4'h3 (sel=0) then 4'h7 (sel=1), both consumers ready → `a_data`=3 one cycle after the first edge, `b_data`=7 one cycle after the second. Each value is valid for exactly one cycle.
- Fill lane A: `a_ready`=0, push 4'h1 and 4'h2 with sel=0 → `a_count`=2 and `in_ready`=0 for sel=0. Switching to sel=1 gives `in_ready`=1, and 4'hF lands in B while A is stalled.
- Full plus pop: lane A full, assert `a_ready`=1 and push sel=0 4'h5 in the same cycle → pop of 1 occurs, push is refused. Next cycle the push is accepted, and A then outputs 2, 5 in order.
- Wrap-around: with DEPTH=2, stream 4'h0..4'hF alternating sel and random ready → each lane emits its words in order, with no loss or duplication after multiple pointer wraps. Scoreboard per lane.
